// File: rtl/bep_pkg.sv
// ---------------------------------------------------------------------------
// bep_pkg
// Shared definitions for the frame controller that sits behind the Manchester
// bit decoder: FSM state encoding, err_code values, the default sync pattern
// and the modulo-256 checksum helper.
// ---------------------------------------------------------------------------
package bep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } state_t;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_SYNC_FAIL = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd2;
    localparam logic [2:0] ERR_CHECKSUM  = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW  = 3'd4;
    localparam logic [2:0] ERR_ABORT     = 3'd5;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Running checksum step; the carry is discarded so the sum stays mod 256.
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] val);
        logic [7:0] res;
        res = acc + val;
        return res;
    endfunction

endpackage

// File: rtl/bep_byte_fifo.sv
// ---------------------------------------------------------------------------
// bep_byte_fifo
// Small synchronous FIFO for payload bytes. Each entry is {last, data}.
// Pointers carry an extra wrap bit so full and empty are distinguishable;
// both flags are registered. A push while full is dropped unless a pop
// happens in the same cycle; a pop while empty is ignored.
// Ports:
//   clock, reset_n  clock / asynchronous active-low reset
//   push, push_data write request and entry
//   pop             read request (consumer handshake)
//   head            entry at the head of the queue
//   empty, full     registered occupancy flags
//   overflow        a push is being dropped this cycle
// ---------------------------------------------------------------------------
module bep_byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic [PTR_W:0]   wr_ptr_next_s;
    logic [PTR_W:0]   rd_ptr_next_s;
    logic             empty_r;
    logic             full_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Handshake qualification and next-pointer computation.
    always_comb begin
        do_pop_s      = pop && !empty_r;
        do_push_s     = push && (!full_r || do_pop_s);
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        if (do_push_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (do_pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
    end

    // Pointer and flag registers; flags are derived from the next pointers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            empty_r  <= (wr_ptr_next_s == rd_ptr_next_s);
            full_r   <= (wr_ptr_next_s[PTR_W] != rd_ptr_next_s[PTR_W]) &&
                        (wr_ptr_next_s[PTR_W-1:0] == rd_ptr_next_s[PTR_W-1:0]);
        end
    end

    // Storage; cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= push_data;
        end
    end

    assign head     = mem_r[rd_ptr_r[PTR_W-1:0]];
    assign empty    = empty_r;
    assign full     = full_r;
    assign overflow = push && full_r && !do_pop_s;

endmodule

// File: rtl/bep_frame_controller.sv
// ---------------------------------------------------------------------------
// bep_frame_controller
// Frame sequencer behind the Manchester bit decoder. Hunts the sync byte,
// then reads length, payload and checksum (MSB-first bytes). Payload bytes
// stream out through a small FIFO; each frame ends with a one-cycle
// frame_ok or frame_err pulse plus a decoder_rearm pulse.
// Ports:
//   clock, reset_n   clock / asynchronous active-low reset
//   frame_start      transmission-begin pulse from the decoder
//   bit_strobe       one decoded bit valid; bit_data holds its value
//   byte_data        payload byte at FIFO head
//   byte_valid       FIFO not empty
//   byte_last        head byte is the final payload byte of its frame
//   byte_ready       consumer accepts the head byte
//   frame_ok         frame completed with good checksum (1 cycle)
//   frame_err        frame failed (1 cycle); reason in err_code
//   err_code         failure reason, held until the next frame_start
//   decoder_rearm    decoder reset pulse after every frame end or error
//   busy             sequencer not idle
// ---------------------------------------------------------------------------
module bep_frame_controller
    import bep_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
    parameter int         SYNC_MAX_BITS = 32,
    parameter int         BIT_TIMEOUT   = 64,
    parameter int         FIFO_DEPTH    = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       bit_strobe,
    input  logic       bit_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_last,
    input  logic       byte_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code,
    output logic       decoder_rearm,
    output logic       busy
);

    localparam int TO_W = $clog2(BIT_TIMEOUT + 1);
    localparam int SC_W = $clog2(SYNC_MAX_BITS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BIT_TIMEOUT - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SYNC_MAX_BITS - 1);
    localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [SC_W-1:0] SC_ONE  = {{(SC_W-1){1'b0}}, 1'b1};

    state_t          state_r;
    state_t          next_state_s;
    logic [2:0]      next_err_s;
    logic [7:0]      shift_r;
    logic [7:0]      shift_next_s;
    logic [2:0]      bit_cnt_r;
    logic [SC_W-1:0] sync_cnt_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [7:0]      rem_r;
    logic [7:0]      sum_r;
    logic [2:0]      err_code_r;
    logic            frame_ok_r;
    logic            frame_err_r;
    logic            rearm_r;
    logic            busy_r;
    logic            push_r;
    logic [8:0]      push_data_r;
    logic            byte_done_s;
    logic            active_s;
    logic            fifo_overflow_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic            fifo_pop_s;
    logic [8:0]      fifo_head_s;

    // Bit-level helpers shared by the FSM and the datapath.
    always_comb begin
        shift_next_s = {shift_r[6:0], bit_data};
        byte_done_s  = bit_strobe && (bit_cnt_r == 3'd7);
        active_s     = (state_r == ST_SYNC) || (state_r == ST_LEN) ||
                       (state_r == ST_PAYLOAD) || (state_r == ST_CSUM);
        fifo_pop_s   = byte_ready;
    end

    // Next-state logic; error sources are applied last in rising priority.
    always_comb begin
        next_state_s = state_r;
        next_err_s   = ERR_NONE;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    next_state_s = ST_SYNC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (bit_strobe && (shift_next_s == SYNC_BYTE)) begin
                    next_state_s = ST_LEN;
                end else if (bit_strobe && (sync_cnt_r == SC_LAST)) begin
                    next_state_s = ST_ERR;
                    next_err_s   = ERR_SYNC_FAIL;
                end else begin
                    next_state_s = ST_SYNC;
                end
            end
            ST_LEN: begin
                if (byte_done_s) begin
                    next_state_s = (shift_next_s == 8'd0) ? ST_CSUM : ST_PAYLOAD;
                end else begin
                    next_state_s = ST_LEN;
                end
            end
            ST_PAYLOAD: begin
                if (byte_done_s && (rem_r == 8'd1)) begin
                    next_state_s = ST_CSUM;
                end else begin
                    next_state_s = ST_PAYLOAD;
                end
            end
            ST_CSUM: begin
                if (byte_done_s && (sum8(sum_r, shift_next_s) == 8'd0)) begin
                    next_state_s = ST_DONE;
                end else if (byte_done_s) begin
                    next_state_s = ST_ERR;
                    next_err_s   = ERR_CHECKSUM;
                end else begin
                    next_state_s = ST_CSUM;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            ST_ERR:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase

        if (active_s && !bit_strobe && (to_cnt_r == TO_LAST)) begin
            next_state_s = ST_ERR;
            next_err_s   = ERR_TIMEOUT;
        end else begin
            next_state_s = next_state_s;
        end

        // A push is issued the cycle after a byte completes, so a drop is
        // seen while still in PAYLOAD or just after moving to CSUM.
        if (fifo_overflow_s && ((state_r == ST_PAYLOAD) || (state_r == ST_CSUM))) begin
            next_state_s = ST_ERR;
            next_err_s   = ERR_OVERFLOW;
        end else begin
            next_state_s = next_state_s;
        end

        if (active_s && frame_start) begin
            next_state_s = ST_ERR;
            next_err_s   = ERR_ABORT;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // State register and registered frame-level outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            err_code_r  <= ERR_NONE;
            frame_ok_r  <= 1'b0;
            frame_err_r <= 1'b0;
            rearm_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            frame_ok_r  <= (next_state_s == ST_DONE);
            frame_err_r <= (next_state_s == ST_ERR);
            rearm_r     <= (next_state_s == ST_DONE) || (next_state_s == ST_ERR);
            busy_r      <= (next_state_s != ST_IDLE);
            if ((state_r == ST_IDLE) && frame_start) begin
                err_code_r <= ERR_NONE;
            end else if ((next_state_s == ST_ERR) && (state_r != ST_ERR)) begin
                err_code_r <= next_err_s;
            end else begin
                err_code_r <= err_code_r;
            end
        end
    end

    // Bit shifter, bit/sync counters and inter-strobe timeout counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_r    <= 8'd0;
            bit_cnt_r  <= 3'd0;
            sync_cnt_r <= '0;
            to_cnt_r   <= '0;
        end else begin
            if ((state_r == ST_IDLE) && frame_start) begin
                shift_r    <= 8'd0;
                bit_cnt_r  <= 3'd0;
                sync_cnt_r <= '0;
            end else if (active_s && bit_strobe) begin
                shift_r <= shift_next_s;
                // The bit counter only runs once byte alignment is known.
                bit_cnt_r  <= (state_r == ST_SYNC) ? 3'd0 : bit_cnt_r + 3'd1;
                sync_cnt_r <= (state_r == ST_SYNC) ? sync_cnt_r + SC_ONE : sync_cnt_r;
            end else begin
                shift_r    <= shift_r;
                bit_cnt_r  <= bit_cnt_r;
                sync_cnt_r <= sync_cnt_r;
            end
            if (!active_s || bit_strobe || (next_state_s != state_r)) begin
                to_cnt_r <= '0;
            end else begin
                to_cnt_r <= to_cnt_r + TO_ONE;
            end
        end
    end

    // Length, checksum accumulator and FIFO push staging.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_r       <= 8'd0;
            sum_r       <= 8'd0;
            push_r      <= 1'b0;
            push_data_r <= 9'd0;
        end else begin
            push_r <= 1'b0;
            if ((state_r == ST_LEN) && byte_done_s) begin
                rem_r <= shift_next_s;
                sum_r <= 8'd0;
            end else if ((state_r == ST_PAYLOAD) && byte_done_s &&
                         ((next_state_s == ST_PAYLOAD) || (next_state_s == ST_CSUM))) begin
                rem_r       <= rem_r - 8'd1;
                sum_r       <= sum8(sum_r, shift_next_s);
                push_r      <= 1'b1;
                push_data_r <= {(rem_r == 8'd1), shift_next_s};
            end else begin
                rem_r <= rem_r;
                sum_r <= sum_r;
            end
        end
    end

    bep_byte_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push_r),
        .push_data (push_data_r),
        .pop       (fifo_pop_s),
        .head      (fifo_head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .overflow  (fifo_overflow_s)
    );

    assign byte_data     = fifo_head_s[7:0];
    assign byte_last     = fifo_head_s[8];
    assign byte_valid    = !fifo_empty_s;
    assign frame_ok      = frame_ok_r;
    assign frame_err     = frame_err_r;
    assign err_code      = err_code_r;
    assign decoder_rearm = rearm_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_bep_frame_controller.sv
// Scoreboard bench for bep_frame_controller: stimulus pushes expected bytes
// and frame outcomes into queues; monitors pop and compare on DUT outputs.
module tb_bep_frame_controller;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       bit_strobe = 1'b0;
    logic       bit_data = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;
    logic       decoder_rearm;
    logic       busy;

    typedef struct {
        logic       ok;
        logic [2:0] code;
        int         at;
    } frame_exp_t;

    logic [8:0] byte_q[$];
    frame_exp_t frame_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_strobe_cyc = 0;

    bep_frame_controller dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .frame_start   (frame_start),
        .bit_strobe    (bit_strobe),
        .bit_data      (bit_data),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .byte_last     (byte_last),
        .byte_ready    (byte_ready),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .decoder_rearm (decoder_rearm),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte monitor: every accepted byte must match the head of byte_q.
    always @(negedge clock) begin
        if (reset_n && byte_valid && byte_ready) begin
            if (byte_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte: got %0h, expected none", {byte_last, byte_data});
            end else begin
                logic [8:0] e;
                e = byte_q.pop_front();
                check("byte", {23'd0, byte_last, byte_data}, {23'd0, e});
            end
        end
    end

    // Frame monitor: each ok/err pulse must match the head of frame_q.
    always @(negedge clock) begin
        if (reset_n && (frame_ok || frame_err)) begin
            if (frame_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_frame: got ok=%0b err=%0b code=%0d, expected none",
                         frame_ok, frame_err, err_code);
            end else begin
                frame_exp_t e;
                e = frame_q.pop_front();
                check("frame_status", {26'd0, frame_ok, frame_err, err_code, decoder_rearm},
                      {26'd0, e.ok, !e.ok, e.code, 1'b1});
                if (e.at >= 0) check("frame_cycle", cyc, e.at);
            end
        end else if (reset_n && decoder_rearm) begin
            n_checks++;
            n_fail++;
            $display("FAIL stray_rearm: got rearm=1, expected 0 without frame pulse");
        end
    end

    task automatic exp_byte(input logic [7:0] d, input logic last);
        byte_q.push_back({last, d});
    endtask

    task automatic exp_frame(input logic ok, input logic [2:0] code, input int at);
        frame_exp_t e;
        e.ok = ok;
        e.code = code;
        e.at = at;
        frame_q.push_back(e);
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic send_bit(input logic b);
        bit_strobe = 1'b1;
        bit_data = b;
        last_strobe_cyc = cyc + 1;
        @(posedge clock); #1;
        bit_strobe = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(posedge clock); #1;
        frame_start = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic wait_frames(input int max_cyc);
        for (int i = 0; i < max_cyc && frame_q.size() != 0; i++) @(posedge clock);
        #1;
        if (frame_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: got %0d pending frames, expected 0", frame_q.size());
            frame_q.delete();
        end
    endtask

    task automatic wait_bytes(input int max_cyc);
        for (int i = 0; i < max_cyc && byte_q.size() != 0; i++) @(posedge clock);
        #1;
        if (byte_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_timeout: got %0d pending bytes, expected 0", byte_q.size());
            byte_q.delete();
        end
    endtask

    initial begin
        logic [31:0] noise;
        noise = 32'hFFFF0000;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {21'd0, busy, byte_valid, frame_ok, frame_err, err_code, decoder_rearm, byte_last},
              32'd0);
        check("reset_byte_data", {24'd0, byte_data}, 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        byte_ready = 1'b1;

        // 1: good frame, three payload bytes
        pulse_start();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        exp_byte(8'h11, 1'b0); exp_byte(8'h22, 1'b0); exp_byte(8'h33, 1'b1);
        exp_frame(1'b1, 3'd0, -1);
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h9A);
        wait_frames(50); wait_bytes(50);
        check("t1_err_code", {29'd0, err_code}, 32'd0);
        check("t1_busy_idle", {31'd0, busy}, 32'd0);

        // 2: bad checksum
        pulse_start();
        exp_byte(8'h11, 1'b0); exp_byte(8'h22, 1'b0); exp_byte(8'h33, 1'b1);
        exp_frame(1'b0, 3'd3, -1);
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h9B);
        wait_frames(50); wait_bytes(50);
        repeat (5) @(posedge clock); #1;
        check("t2_err_code_held", {29'd0, err_code}, 32'd3);

        // 3: zero-length frame, then sync failure on noise
        pulse_start();
        check("t3_err_code_cleared", {29'd0, err_code}, 32'd0);
        exp_frame(1'b1, 3'd0, -1);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        wait_frames(50);
        check("t3_no_bytes", {31'd0, byte_valid}, 32'd0);
        pulse_start();
        exp_frame(1'b0, 3'd1, -1);
        for (int i = 31; i >= 0; i--) send_bit(noise[i]);
        wait_frames(50);

        // 4: consumer stalled, FIFO overflow on the fifth payload byte
        byte_ready = 1'b0;
        pulse_start();
        exp_frame(1'b0, 3'd4, -1);
        send_byte(8'hA5); send_byte(8'h06);
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        wait_frames(50);
        check("t4_head_held", {23'd0, byte_valid, byte_data}, {23'd0, 1'b1, 8'h01});
        for (int i = 1; i <= 4; i++) exp_byte(8'(i), 1'b0);
        byte_ready = 1'b1;
        wait_bytes(50);
        check("t4_drained", {31'd0, byte_valid}, 32'd0);

        // 5a: strobes stop mid-payload
        pulse_start();
        exp_byte(8'h11, 1'b0);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        exp_frame(1'b0, 3'd2, last_strobe_cyc + 64);
        wait_frames(120); wait_bytes(20);

        // 5b: new transmission begins while reading length
        pulse_start();
        send_byte(8'hA5);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        exp_frame(1'b0, 3'd5, -1);
        pulse_start();
        wait_frames(20);
        repeat (3) @(posedge clock); #1;
        check("t5_not_restarted", {31'd0, busy}, 32'd0);

        // 6: asynchronous reset mid-payload with bytes waiting in the FIFO
        byte_ready = 1'b0;
        pulse_start();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("t6_pre_reset_valid", {31'd0, byte_valid}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_async_reset", {21'd0, busy, byte_valid, frame_ok, frame_err, err_code, decoder_rearm, byte_last},
              32'd0);
        check("t6_byte_data", {24'd0, byte_data}, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        byte_ready = 1'b1;
        repeat (5) @(posedge clock); #1;
        check("leftover_frames", frame_q.size(), 32'd0);
        check("leftover_bytes", byte_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
